// File: rtl/mux7_sched_pkg.sv
// Shared constants and helpers for the 7-requester round-robin scheduler.
//   N_REQ    : number of requesters sharing the mux datapath
//   SEL_W    : width of the mux select / requester index
//   BURST_W  : width of the lock burst counter (MUX7_LOCK_EN builds)
//   next_idx : requester index successor, wrapping 6 -> 0
package mux7_sched_pkg;

    localparam int N_REQ   = 7;
    localparam int SEL_W   = 3;
    localparam int BURST_W = 4;

    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
        return (i == 3'd6) ? 3'd0 : i + 3'd1;
    endfunction

endpackage

// File: rtl/mux7_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr, ascending, wrapping 6 -> 0; the first set bit wins.
//   req [6:0] in  : pending requesters
//   ptr [2:0] in  : highest-priority index this cycle (0..6)
//   any       out : at least one requester pending
//   idx [2:0] out : winning index (0 when nothing pending, never 7)
module mux7_rr_pick
    import mux7_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] j;

    always_comb begin
        any = 1'b0;
        idx = '0;
        // An out-of-range pointer cannot occur, but fold it onto 0 so the search stays in 0..6.
        j   = (ptr > 3'd6) ? 3'd0 : ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[j]) begin
                any = 1'b1;
                idx = j;
            end
            j = next_idx(j);
        end
    end

endmodule

// File: rtl/mux7_rr_scheduler.sv
// Round-robin scheduler in front of a shared 7:1 mux. Each cycle at most one
// pending requester is accepted; its word is registered into out_data with a
// valid/ready handshake, and sel reports which requester the word came from.
// Optional macro MUX7_LOCK_EN adds the lock port and burst locking: a locked
// winner keeps top priority for up to MAX_BURST consecutive grants.
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   req[6:0]   in  : request per requester
//   din[7*W]   in  : packed requester data, requester k at [k*W +: W]
//   gnt[6:0]   out : one-hot accept, din[k] captured on this edge
//   sel[2:0]   out : registered index of the word in out_data
//   out_valid  out : out_data holds a valid word
//   out_data   out : registered selected word
//   out_ready  in  : downstream accept
//   lock[6:0]  in  : burst request per requester (MUX7_LOCK_EN only)
module mux7_rr_scheduler
    import mux7_sched_pkg::*;
#(
    parameter int W = 1
`ifdef MUX7_LOCK_EN
   ,parameter int MAX_BURST = 4
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] din,
    output logic [N_REQ-1:0]   gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
`ifdef MUX7_LOCK_EN
    input  logic [N_REQ-1:0]   lock,
`endif
    input  logic               out_ready
);

    logic [SEL_W-1:0] ptr;
    logic             any;
    logic [SEL_W-1:0] idx;
    logic             can_load;
    logic             load;
    logic [W-1:0]     word;

    mux7_rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .idx (idx)
    );

    assign can_load = !out_valid || out_ready;
    assign load     = can_load && any;
    assign word     = din[int'(idx)*W +: W];

    always_comb begin
        gnt = '0;
        if (load) gnt[idx] = 1'b1;
    end

`ifdef MUX7_LOCK_EN
    logic [BURST_W-1:0] burst_cnt;
    logic [BURST_W-1:0] burst_base;
    logic               stay;

    // sel still holds the previous winner; a different winner restarts the burst count.
    assign burst_base = (idx == sel) ? burst_cnt : '0;
    assign stay       = lock[idx] && (burst_base < BURST_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (load) begin
            burst_cnt <= stay ? burst_base + 1'b1 : '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            sel       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (can_load) begin
            if (any) begin
                out_data  <= word;
                sel       <= idx;
                out_valid <= 1'b1;
`ifdef MUX7_LOCK_EN
                ptr       <= stay ? idx : next_idx(idx);
`else
                ptr       <= next_idx(idx);
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux7_rr_scheduler.sv
module tb_mux7_rr_scheduler;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     req = '0;
    logic [7*W-1:0] din;
    logic [6:0]     gnt;
    logic [2:0]     sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready = 1'b1;
`ifdef MUX7_LOCK_EN
    logic [6:0]     lock = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux7_rr_scheduler #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
`ifdef MUX7_LOCK_EN
        .lock      (lock),
`endif
        .out_ready (out_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Default data pattern: requester k presents 8'h10 + k.
    task automatic set_din_default();
        for (int k = 0; k < 7; k++) din[k*W +: W] = 8'(8'h10 + k);
    endtask

    // Inputs are set after a negedge; check the combinational grant, take the
    // rising edge, then check the registered outputs at the following negedge.
    task automatic step(input string tag, input logic [6:0] exp_gnt, input logic [2:0] exp_sel,
                        input logic [7:0] exp_data, input logic exp_valid);
        #1;
        check_val({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
        @(posedge clk);
        @(negedge clk);
        check_val({tag, " sel"}, 32'(sel), 32'(exp_sel));
        check_val({tag, " data"}, 32'(out_data), 32'(exp_data));
        check_val({tag, " valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_din_default();
        @(negedge clk);
        check_val("rst valid", 32'(out_valid), 32'd0);
        check_val("rst sel", 32'(sel), 32'd0);
        check_val("rst data", 32'(out_data), 32'd0);
        check_val("rst gnt", 32'(gnt), 32'd0);
        rst_n = 1'b1;

        // 1: two requesters alternate
        req = 7'b0010001;
        step("t1a", 7'h01, 3'd0, 8'h10, 1'b1);
        step("t1b", 7'h10, 3'd4, 8'h14, 1'b1);
        step("t1c", 7'h01, 3'd0, 8'h10, 1'b1);

        // 2: all requesting, full rotation twice, no bubbles
        do_reset();
        req = 7'h7F;
        for (int c = 0; c < 14; c++) begin
            step($sformatf("t2_%0d", c), 7'(7'h01 << (c % 7)), 3'(c % 7), 8'(8'h10 + (c % 7)), 1'b1);
        end

        // 3: backpressure holds the word and blocks grants
        do_reset();
        din[3*W +: W] = 8'h01;
        req = 7'h08;
        step("t3load", 7'h08, 3'd3, 8'h01, 1'b1);
        req = 7'h7F;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step($sformatf("t3bp%0d", c), 7'h00, 3'd3, 8'h01, 1'b1);
        end
        out_ready = 1'b1;
        step("t3rel", 7'h10, 3'd4, 8'h14, 1'b1);
        set_din_default();

        // 4: wrap 6 -> 0 (ptr steered to 6 by serving requester 5)
        do_reset();
        req = 7'h20;
        step("t4pre", 7'h20, 3'd5, 8'h15, 1'b1);
        req = 7'h41;
        step("t4a", 7'h40, 3'd6, 8'h16, 1'b1);
        step("t4b", 7'h01, 3'd0, 8'h10, 1'b1);
        step("t4c", 7'h40, 3'd6, 8'h16, 1'b1);

        // idle with ready: valid drops, sel and data hold
        req = '0;
        step("idle", 7'h00, 3'd6, 8'h16, 1'b0);

        // 5: asynchronous reset mid-transfer
        do_reset();
        req = 7'h20;
        step("t5pre", 7'h20, 3'd5, 8'h15, 1'b1);
        req = '0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("t5 rst valid", 32'(out_valid), 32'd0);
        check_val("t5 rst sel", 32'(sel), 32'd0);
        check_val("t5 rst data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        req = 7'h60;
        step("t5post", 7'h20, 3'd5, 8'h15, 1'b1);

`ifdef MUX7_LOCK_EN
        // 6: burst lock on requester 0, MAX_BURST = 4
        do_reset();
        req  = 7'h03;
        lock = 7'h01;
        for (int c = 0; c < 10; c++) begin
            logic [2:0] e;
            e = (c == 4 || c == 9) ? 3'd1 : 3'd0;
            step($sformatf("t6_%0d", c), 7'(7'h01 << e), e, 8'(8'h10 + e), 1'b1);
        end
        lock = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
